// File: rtl/sample_byte_serializer.sv
// sample_byte_serializer
// Splits 16-bit ADC samples into an 8-bit byte stream, MSB first, with an
// optional per-packet sequence header byte. The output tlast marks the final
// byte of each packet so the downstream COBS encoder frames one packet at a time.
module sample_byte_serializer #(
  parameter int ENABLE_SEQ  = 1,
  parameter int MAX_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  // sample stream (slave side)
  input  logic [15:0] sample_tdata,
  input  logic        sample_tvalid,
  output logic        sample_tready,
  input  logic        sample_tlast,
  input  logic        sample_tuser,
  // byte stream (master side)
  output logic [7:0]  byte_tdata,
  output logic        byte_tvalid,
  input  logic        byte_tready,
  output logic        byte_tlast,
  output logic        byte_tuser
);

  localparam int CW = $clog2(MAX_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_SEQ = 2'd1,
    SEND_HI  = 2'd2,
    SEND_LO  = 2'd3
  } state_t;

  state_t          state_r,     state_nx_s;
  logic [15:0]     hold_data_r, hold_data_nx_s;
  logic            hold_last_r, hold_last_nx_s;
  logic [7:0]      seq_r,       seq_nx_s;
  logic            sof_r,       sof_nx_s;
  logic [CW-1:0]   count_r,     count_nx_s;
  logic [7:0]      tdata_r,     tdata_nx_s;
  logic            tvalid_r,    tvalid_nx_s;
  logic            tlast_r,     tlast_nx_s;

  logic            sample_hs_s;
  logic            byte_hs_s;
  logic            unused_s;

  // The sample user sideband carries nothing this block needs.
  assign unused_s = sample_tuser;

  assign byte_tdata  = tdata_r;
  assign byte_tvalid = tvalid_r;
  assign byte_tlast  = tlast_r;
  assign byte_tuser  = 1'b0;

  assign sample_hs_s = sample_tvalid & sample_tready;
  assign byte_hs_s   = tvalid_r & byte_tready;

  // Sample acceptance: always when idle, and on the LSB byte only when that
  // byte is leaving, so the next sample can follow with no bubble.
  always_comb begin
    sample_tready = 1'b0;
    case (state_r)
      IDLE:    sample_tready = 1'b1;
      SEND_LO: sample_tready = byte_tready;
      default: sample_tready = 1'b0;
    endcase
  end

  // Next-state, bookkeeping and next registered output values.
  always_comb begin
    state_nx_s     = state_r;
    hold_data_nx_s = hold_data_r;
    hold_last_nx_s = hold_last_r;
    seq_nx_s       = seq_r;
    sof_nx_s       = sof_r;
    count_nx_s     = count_r;
    tdata_nx_s     = tdata_r;
    tvalid_nx_s    = tvalid_r;
    tlast_nx_s     = tlast_r;

    case (state_r)
      IDLE: begin
        state_nx_s = IDLE;
      end
      SEND_SEQ: begin
        if (byte_hs_s) begin
          state_nx_s = SEND_HI;
          sof_nx_s   = 1'b0;
        end else begin
          state_nx_s = SEND_SEQ;
        end
      end
      SEND_HI: begin
        if (byte_hs_s) begin
          state_nx_s = SEND_LO;
        end else begin
          state_nx_s = SEND_HI;
        end
      end
      SEND_LO: begin
        if (byte_hs_s) begin
          state_nx_s = IDLE;
          if (hold_last_r) begin
            count_nx_s = {CW{1'b0}};
            sof_nx_s   = 1'b1;
            seq_nx_s   = seq_r + 8'd1;
          end else begin
            count_nx_s = count_r + CW'(1);
          end
        end else begin
          state_nx_s = SEND_LO;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // A new sample is judged against the count/sof as already updated by the
    // byte leaving this cycle, so back-to-back samples are numbered correctly.
    if (sample_hs_s) begin
      hold_data_nx_s = sample_tdata;
      hold_last_nx_s = sample_tlast | (count_nx_s == CW'(MAX_SAMPLES - 1));
      state_nx_s     = (sof_nx_s && (ENABLE_SEQ != 0)) ? SEND_SEQ : SEND_HI;
    end else begin
      hold_data_nx_s = hold_data_nx_s;
    end

    // Output values follow the state being entered; with no handshake every
    // input to this decode is unchanged, so a stalled byte stays stable.
    case (state_nx_s)
      IDLE: begin
        tvalid_nx_s = 1'b0;
        tdata_nx_s  = 8'd0;
        tlast_nx_s  = 1'b0;
      end
      SEND_SEQ: begin
        tvalid_nx_s = 1'b1;
        tdata_nx_s  = seq_nx_s;
        tlast_nx_s  = 1'b0;
      end
      SEND_HI: begin
        tvalid_nx_s = 1'b1;
        tdata_nx_s  = hold_data_nx_s[15:8];
        tlast_nx_s  = 1'b0;
      end
      SEND_LO: begin
        tvalid_nx_s = 1'b1;
        tdata_nx_s  = hold_data_nx_s[7:0];
        tlast_nx_s  = hold_last_nx_s;
      end
      default: begin
        tvalid_nx_s = 1'b0;
        tdata_nx_s  = 8'd0;
        tlast_nx_s  = 1'b0;
      end
    endcase
  end

  // State, holding and output registers; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      hold_data_r <= 16'd0;
      hold_last_r <= 1'b0;
      seq_r       <= 8'd0;
      sof_r       <= 1'b1;
      count_r     <= {CW{1'b0}};
      tdata_r     <= 8'd0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      hold_data_r <= hold_data_nx_s;
      hold_last_r <= hold_last_nx_s;
      seq_r       <= seq_nx_s;
      sof_r       <= sof_nx_s;
      count_r     <= count_nx_s;
      tdata_r     <= tdata_nx_s;
      tvalid_r    <= tvalid_nx_s;
      tlast_r     <= tlast_nx_s;
    end
  end

endmodule

// File: tb/tb_sample_byte_serializer.sv
// tb_sample_byte_serializer
// Scoreboard bench: each driven sample pushes its expected bytes; a monitor
// pops and compares on every output handshake and checks stall stability.
module tb_sample_byte_serializer;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;

  logic [8:0]  sb_q[$];
  int          total = 0;
  int          bad   = 0;

  // reference model of packet framing
  logic        mdl_sof;
  logic [7:0]  mdl_seq;
  int          mdl_cnt;

  logic        toggle_rdy = 1'b0;
  logic        cnt_en     = 1'b0;
  int          v_cycles, rdy_cycles, run_len, max_run;

  sample_byte_serializer #(.ENABLE_SEQ(1), .MAX_SAMPLES(MAX)) dut (
    .clk(clk), .rst(rst),
    .sample_tdata(s_tdata), .sample_tvalid(s_tvalid), .sample_tready(s_tready),
    .sample_tlast(s_tlast), .sample_tuser(s_tuser),
    .byte_tdata(m_tdata), .byte_tvalid(m_tvalid), .byte_tready(m_tready),
    .byte_tlast(m_tlast), .byte_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_sof = 1'b1;
    mdl_seq = 8'd0;
    mdl_cnt = 0;
    sb_q.delete();
  endtask

  task automatic push_expected(input logic [15:0] d, input logic l);
    logic lst;
    if (mdl_sof) begin
      sb_q.push_back({1'b0, mdl_seq});
      mdl_sof = 1'b0;
    end
    lst = l | (mdl_cnt == MAX - 1);
    sb_q.push_back({1'b0, d[15:8]});
    sb_q.push_back({lst, d[7:0]});
    if (lst) begin
      mdl_cnt = 0;
      mdl_sof = 1'b1;
      mdl_seq = mdl_seq + 8'd1;
    end else begin
      mdl_cnt++;
    end
  endtask

  // Present one sample and wait (bounded) for its handshake; tvalid stays high.
  task automatic send(input logic [15:0] d, input logic l);
    logic hs;
    int   n;
    push_expected(d, l);
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = 1'($urandom);
    s_tvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", 32'(hs), 32'd1);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Downstream ready: steady high or toggling every cycle.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_rdy) m_tready = ~m_tready;
      else            m_tready = 1'b1;
    end
  end

  // Output monitor on the falling edge.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] exp;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(m_tvalid), 32'd1);
          chk("stall_data", 32'(m_tdata), 32'(prev_data));
          chk("stall_last", 32'(m_tlast), 32'(prev_last));
        end
        if (cnt_en) begin
          if (m_tvalid) begin
            v_cycles++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (s_tready) rdy_cycles++;
          end else begin
            run_len = 0;
          end
        end
        if (m_tvalid && m_tready) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            exp = sb_q.pop_front();
            chk("byte_data", 32'(m_tdata), 32'(exp[7:0]));
            chk("byte_last", 32'(m_tlast), 32'(exp[8]));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_tdata = 16'd0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_tdata),  32'd0);
    chk("rst_tlast",  32'(m_tlast),  32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);
    chk("rst_tuser",  32'(m_tuser),  32'd0);

    // basic two-sample packet: 00 12 34 AB CD, first byte 1 cycle after accept
    send(16'h1234, 1'b0);
    chk("latency_valid", 32'(m_tvalid), 32'd1);
    chk("first_hdr", 32'(m_tdata), 32'h00);
    send(16'hABCD, 1'b1);
    idle();
    drain();

    // same stimulus with downstream ready toggling
    do_reset();
    toggle_rdy = 1'b1;
    send(16'h1234, 1'b0);
    send(16'hABCD, 1'b1);
    idle();
    drain();
    toggle_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // back-to-back 3-sample packet: 7 contiguous bytes, ready on 3 LSB cycles
    v_cycles = 0; rdy_cycles = 0; run_len = 0; max_run = 0;
    cnt_en = 1'b1;
    send(16'h0A0B, 1'b0);
    send(16'h0C0D, 1'b0);
    send(16'h0E0F, 1'b1);
    idle();
    drain();
    cnt_en = 1'b0;
    chk("burst_valid_cycles", 32'(v_cycles), 32'd7);
    chk("burst_contiguous", 32'(max_run), 32'd7);
    chk("burst_ready_cycles", 32'(rdy_cycles), 32'd3);

    // 257 one-sample packets: headers 00..FF then wrap to 00
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send(16'h5A5A, 1'b1);
    end
    idle();
    drain();
    chk("seq_wrap_model", 32'(mdl_seq), 32'h01);

    // packet length forced by the sample limit
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      send(16'(i), 1'b0);
    end
    idle();
    drain();

    // reset mid-packet after the MSB byte of the second sample
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    idle();
    begin
      int n;
      n = 0;
      while (sb_q.size() != 1 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("pre_rst_queue", 32'(sb_q.size()), 32'd1);
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_tlast",  32'(m_tlast),  32'd0);
    send(16'h3333, 1'b1);
    chk("post_rst_hdr", 32'(m_tdata), 32'h00);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
